accel_burst_reader: RTL and testbench

ACCEL_BURST_READER -- requirements
Module: accel_burst_reader

---
 rtl/accel_burst_reader.sv | 198 +++++++++++++++++++
 tb/tb_accel_burst_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_burst_reader.sv
// Periodic SPI burst reader for a 3-axis accelerometer: one multibyte read of
// six data registers per sample tick, published as signed X/Y/Z samples.
module accel_burst_reader #(
    parameter logic [7:0]  START_ADDR    = 8'h32,
    parameter int unsigned SAMPLE_PERIOD = 100000
) (
    input  logic        CLK100MHZ,
    input  logic        RESET,
    input  logic        ENABLE,
    output logic [2:0]  spi_tx_count,
    output logic [7:0]  spi_tx_byte,
    output logic        spi_tx_dv,
    input  logic        spi_tx_ready,
    input  logic [7:0]  spi_rx_byte,
    input  logic        spi_rx_dv,
    output logic [15:0] sample_x,
    output logic [15:0] sample_y,
    output logic [15:0] sample_z,
    output logic        sample_valid,
    output logic        overrun
);

    localparam int unsigned CNT_W     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned BURST_LEN = 7;
    localparam int unsigned IDX_W     = 3;
    localparam logic [7:0]  CMD_BYTE  = {1'b1, 1'b1, START_ADDR[5:0]};
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEND_CMD   = 3'd1,
        S_WAIT_LOW   = 3'd2,
        S_WAIT_HIGH  = 3'd3,
        S_SEND_DUMMY = 3'd4,
        S_COLLECT    = 3'd5,
        S_PUBLISH    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               tick_c;
    logic [IDX_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]   rx_idx_q, rx_idx_d;
    logic [5:0][7:0]    shadow_q, shadow_d;
    logic [2:0]         spi_tx_count_q, spi_tx_count_d;
    logic [7:0]         spi_tx_byte_q, spi_tx_byte_d;
    logic               spi_tx_dv_q, spi_tx_dv_d;
    logic [15:0]        sample_x_q, sample_x_d;
    logic [15:0]        sample_y_q, sample_y_d;
    logic [15:0]        sample_z_q, sample_z_d;
    logic               sample_valid_q, sample_valid_d;
    logic               overrun_q, overrun_d;

    // Free-running sample timebase, independent of ENABLE
    assign tick_c = (tick_cnt_q == TICK_LAST);

    // State register
    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (tick_c && ENABLE) state_d = S_SEND_CMD;
            end
            S_SEND_CMD: begin
                if (spi_tx_ready) state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!spi_tx_ready) state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (spi_tx_ready) begin
                    state_d = (tx_cnt_q < IDX_FULL) ? S_SEND_DUMMY : S_COLLECT;
                end
            end
            S_SEND_DUMMY: begin
                if (spi_tx_ready) state_d = S_WAIT_LOW;
            end
            S_COLLECT: begin
                if (rx_idx_q == IDX_FULL) state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values
    always_comb begin
        tick_cnt_d     = tick_c ? '0 : tick_cnt_q + 1'b1;
        tx_cnt_d       = tx_cnt_q;
        rx_idx_d       = rx_idx_q;
        shadow_d       = shadow_q;
        spi_tx_count_d = 3'(BURST_LEN);
        spi_tx_byte_d  = spi_tx_byte_q;
        spi_tx_dv_d    = 1'b0;
        sample_x_d     = sample_x_q;
        sample_y_d     = sample_y_q;
        sample_z_d     = sample_z_q;
        sample_valid_d = 1'b0;
        overrun_d      = overrun_q | (tick_c && (state_q != S_IDLE));

        unique case (state_q)
            S_IDLE: begin
                if (tick_c && ENABLE) begin
                    tx_cnt_d = '0;
                    rx_idx_d = '0;
                end
            end
            S_SEND_CMD: begin
                if (spi_tx_ready) begin
                    spi_tx_dv_d   = 1'b1;
                    spi_tx_byte_d = CMD_BYTE;
                    tx_cnt_d      = IDX_W'(1);
                end
            end
            S_SEND_DUMMY: begin
                // Dummy bytes only clock the read data out of the device
                if (spi_tx_ready) begin
                    spi_tx_dv_d   = 1'b1;
                    spi_tx_byte_d = 8'h00;
                    tx_cnt_d      = tx_cnt_q + 1'b1;
                end
            end
            S_COLLECT: begin
                if (rx_idx_q == IDX_FULL) begin
                    sample_x_d     = {shadow_q[1], shadow_q[0]};
                    sample_y_d     = {shadow_q[3], shadow_q[2]};
                    sample_z_d     = {shadow_q[5], shadow_q[4]};
                    sample_valid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Index 0 is the command echo; indices 1..6 are little-endian axis bytes
        if ((state_q != S_IDLE) && spi_rx_dv && (rx_idx_q != IDX_FULL)) begin
            if (rx_idx_q != '0) begin
                shadow_d[rx_idx_q - 1'b1] = spi_rx_byte;
            end
            rx_idx_d = rx_idx_q + 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            tick_cnt_q     <= '0;
            tx_cnt_q       <= '0;
            rx_idx_q       <= '0;
            shadow_q       <= '0;
            spi_tx_count_q <= 3'(BURST_LEN);
            spi_tx_byte_q  <= 8'h00;
            spi_tx_dv_q    <= 1'b0;
            sample_x_q     <= 16'h0000;
            sample_y_q     <= 16'h0000;
            sample_z_q     <= 16'h0000;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            tx_cnt_q       <= tx_cnt_d;
            rx_idx_q       <= rx_idx_d;
            shadow_q       <= shadow_d;
            spi_tx_count_q <= spi_tx_count_d;
            spi_tx_byte_q  <= spi_tx_byte_d;
            spi_tx_dv_q    <= spi_tx_dv_d;
            sample_x_q     <= sample_x_d;
            sample_y_q     <= sample_y_d;
            sample_z_q     <= sample_z_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign spi_tx_count = spi_tx_count_q;
    assign spi_tx_byte  = spi_tx_byte_q;
    assign spi_tx_dv    = spi_tx_dv_q;
    assign sample_x     = sample_x_q;
    assign sample_y     = sample_y_q;
    assign sample_z     = sample_z_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_accel_burst_reader.sv
// Directed bench for accel_burst_reader with a behavioural SPI master model.
module tb_accel_burst_reader;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic [2:0]  spi_tx_count;
    logic [7:0]  spi_tx_byte;
    logic        spi_tx_dv;
    logic        m_ready = 1'b1;
    logic [7:0]  m_rx_byte = 8'h00;
    logic        m_rx_dv = 1'b0;
    logic        stray_dv = 1'b0;
    logic [7:0]  stray_byte = 8'h00;
    wire  [7:0]  rx_byte_w = stray_dv ? stray_byte : m_rx_byte;
    wire         rx_dv_w   = m_rx_dv | stray_dv;
    logic [15:0] sample_x, sample_y, sample_z;
    logic        sample_valid;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int lat = 2;
    int m_cnt = 0;
    int m_idx = 0;
    logic m_busy = 1'b0;
    logic [7:0] resp [7];
    logic [7:0] tx_log [$];
    int dv_viol = 0;
    int valid_cnt = 0;
    logic prev_dv = 1'b0;

    accel_burst_reader #(.START_ADDR(8'h32), .SAMPLE_PERIOD(64)) dut (
        .CLK100MHZ    (clk),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .spi_tx_count (spi_tx_count),
        .spi_tx_byte  (spi_tx_byte),
        .spi_tx_dv    (spi_tx_dv),
        .spi_tx_ready (m_ready),
        .spi_rx_byte  (rx_byte_w),
        .spi_rx_dv    (rx_dv_w),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // SPI master: drops ready on each accepted byte, returns a response after lat cycles
    always @(posedge clk) begin
        m_rx_dv <= 1'b0;
        if (RESET) begin
            m_ready <= 1'b1;
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_idx   <= 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_ready   <= 1'b1;
                m_busy    <= 1'b0;
                m_rx_dv   <= 1'b1;
                m_rx_byte <= (m_idx < 7) ? resp[m_idx] : 8'h00;
                m_idx     <= m_idx + 1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (spi_tx_dv) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            m_cnt   <= lat;
            if (spi_tx_byte == 8'hF2) m_idx <= 0;
        end
    end

    // Interface monitor sampled on the falling edge
    always @(negedge clk) begin
        if (spi_tx_dv) begin
            tx_log.push_back(spi_tx_byte);
            if (!m_ready) dv_viol++;
            if (prev_dv) dv_viol++;
        end
        prev_dv = spi_tx_dv;
        if (sample_valid) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_resp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                             input logic [7:0] b6);
        resp[0] = b0; resp[1] = b1; resp[2] = b2; resp[3] = b3;
        resp[4] = b4; resp[5] = b5; resp[6] = b6;
    endtask

    task automatic stray(input logic [7:0] b);
        stray_byte = b;
        stray_dv   = 1'b1;
        @(posedge clk);
        #1;
        stray_dv   = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output logic got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(posedge clk);
            #1;
            if (sample_valid) got = 1'b1;
        end
    endtask

    task automatic check_burst_bytes(input string tag);
        int bad;
        logic [7:0] first;
        bad = 0;
        first = (tx_log.size() > 0) ? tx_log[0] : 8'h00;
        for (int i = 1; i < tx_log.size(); i++) if (tx_log[i] !== 8'h00) bad++;
        check({tag, "_tx_pulses"}, 32'(tx_log.size()), 32'd7);
        check({tag, "_cmd_byte"}, 32'(first), 32'hF2);
        check({tag, "_dummy_bytes"}, 32'(bad), 32'd0);
        check({tag, "_dv_rules"}, 32'(dv_viol), 32'd0);
    endtask

    initial begin
        logic got;
        int v0;
        load_resp(8'hE5, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'h00, 8'h80);

        // Reset state
        cycles(3);
        check("rst_tx_dv", 32'(spi_tx_dv), 32'd0);
        check("rst_tx_byte", 32'(spi_tx_byte), 32'h00);
        check("rst_tx_count", 32'(spi_tx_count), 32'd7);
        check("rst_x", 32'(sample_x), 32'h0);
        check("rst_y", 32'(sample_y), 32'h0);
        check("rst_z", 32'(sample_z), 32'h0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        RESET = 1'b0;

        // Stray rx strobes while idle
        stray(8'h5A);
        stray(8'hA5);
        cycles(2);
        check("stray0_x", 32'(sample_x), 32'h0);
        check("stray0_valid_cnt", 32'(valid_cnt), 32'd0);

        // Burst A: normal burst
        tx_log.delete();
        dv_viol = 0;
        ENABLE = 1'b1;
        wait_valid(200, got);
        ENABLE = 1'b0;
        check("A_valid_seen", 32'(got), 32'd1);
        check("A_x", 32'(sample_x), 32'h1234);
        check("A_y", 32'(sample_y), 32'hFFFF);
        check("A_z", 32'(sample_z), 32'h8000);
        check("A_overrun", 32'(overrun), 32'd0);
        cycles(15);
        check_burst_bytes("A");
        check("A_valid_cnt", 32'(valid_cnt), 32'd1);

        // ENABLE low for three periods, with stray strobes
        tx_log.delete();
        v0 = valid_cnt;
        cycles(70);
        stray(8'h77);
        cycles(130);
        check("dis_tx_pulses", 32'(tx_log.size()), 32'd0);
        check("dis_overrun", 32'(overrun), 32'd0);
        check("dis_x_hold", 32'(sample_x), 32'h1234);
        check("dis_y_hold", 32'(sample_y), 32'hFFFF);
        check("dis_z_hold", 32'(sample_z), 32'h8000);
        check("dis_valid_cnt", 32'(valid_cnt), 32'(v0));

        // Burst B: boundary values
        load_resp(8'hE5, 8'h01, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h7F);
        tx_log.delete();
        ENABLE = 1'b1;
        wait_valid(200, got);
        ENABLE = 1'b0;
        check("B_valid_seen", 32'(got), 32'd1);
        check("B_x", 32'(sample_x), 32'h0001);
        check("B_y", 32'(sample_y), 32'h8000);
        check("B_z", 32'(sample_z), 32'h7FFF);
        cycles(15);
        check_burst_bytes("B");

        // Reset after the third rx byte, then a fresh burst
        load_resp(8'hE5, 8'h78, 8'h56, 8'h34, 8'h12, 8'hCD, 8'hAB);
        ENABLE = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (m_idx == 3) got = 1'b1;
        end
        check("C_third_rx_seen", 32'(got), 32'd1);
        v0 = valid_cnt;
        RESET = 1'b1;
        cycles(1);
        RESET = 1'b0;
        check("C_rst_x", 32'(sample_x), 32'h0);
        check("C_rst_y", 32'(sample_y), 32'h0);
        check("C_rst_z", 32'(sample_z), 32'h0);
        check("C_rst_tx_dv", 32'(spi_tx_dv), 32'd0);
        tx_log.delete();
        cycles(60);
        check("C_quiet_tx", 32'(tx_log.size()), 32'd0);
        check("C_no_valid", 32'(valid_cnt), 32'(v0));
        wait_valid(200, got);
        ENABLE = 1'b0;
        check("C_valid_seen", 32'(got), 32'd1);
        check("C_x", 32'(sample_x), 32'h5678);
        check("C_y", 32'(sample_y), 32'h1234);
        check("C_z", 32'(sample_z), 32'hABCD);
        cycles(15);
        check_burst_bytes("C");
        check("C_valid_cnt", 32'(valid_cnt), 32'(v0 + 1));

        // Overrun: slow master spans a second tick
        load_resp(8'hE5, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00);
        lat = 10;
        tx_log.delete();
        ENABLE = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 150 && !got; i++) begin
            @(posedge clk);
            #1;
            if (tx_log.size() > 0) got = 1'b1;
        end
        check("D_burst_started", 32'(got), 32'd1);
        check("D_overrun_before", 32'(overrun), 32'd0);
        wait_valid(300, got);
        check("D_valid_seen", 32'(got), 32'd1);
        check("D_overrun_after", 32'(overrun), 32'd1);
        check("D_x", 32'(sample_x), 32'h8000);
        check("D_y", 32'(sample_y), 32'h0001);
        check("D_z", 32'(sample_z), 32'h0000);
        check("D_tx_pulses", 32'(tx_log.size()), 32'd7);

        // Clean burst afterwards: overrun stays sticky
        lat = 2;
        load_resp(8'hE5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
        tx_log.delete();
        wait_valid(200, got);
        ENABLE = 1'b0;
        check("E_valid_seen", 32'(got), 32'd1);
        check("E_x", 32'(sample_x), 32'h2211);
        check("E_y", 32'(sample_y), 32'h4433);
        check("E_z", 32'(sample_z), 32'h6655);
        cycles(70);
        check_burst_bytes("E");
        check("E_overrun_sticky", 32'(overrun), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
